// File: rtl/seq_mul_shift_add.sv
// seq_mul_shift_add: N-iteration shift-and-add unsigned multiplier with start/busy/done handshake
module seq_mul_shift_add #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   p
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [2*N-1:0] acc, mcand, sum;
  logic [N-1:0] mplier;
  logic [CW-1:0] count;
  logic accept, last;
  always_comb begin
    accept  = start && state != RUN;
    last    = state == RUN && count == CW'(N - 1);
    sum     = acc + (mplier[0] ? mcand : '0);
    state_n = accept ? RUN : last ? DONE : state == DONE ? IDLE : state;
    busy    = state == RUN;
    done    = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      p      <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
      count  <= '0;
    end else if (state == RUN) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (last) p <= sum;
    end
  end
endmodule

// File: doc/seq_mul_shift_add.md
Name: seq_mul_shift_add

Overview:
Sequential unsigned multiplier built on the team's 16-bit add datapath. Each cycle it performs one conditional add and shift, and produces a 2N-bit product after N iterations. It consumes the adder's sum every cycle and feeds the next stage through a start/busy/done handshake. It serves as the multi-cycle arithmetic stage directly downstream of the combinational adder.

Parameters:
N, 8, operand width in bits; product width is 2N (16 at default).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request a multiply; sampled only when busy=0
a  input  N  multiplicand, captured on an accepted start
b  input  N  multiplier, captured on an accepted start
busy  output  1  high while iterations are in progress
done  output  1  one-cycle pulse when p becomes valid
p  output  2N  product; holds its value until the next completion

Behaviour:
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Reset (rst=1 at an edge) forces: state=IDLE, busy=0, done=0, p=0, internal acc=0, mcand=0, mplier=0, count=0. Reset has priority over every other input.
- Reset mid-RUN abandons the operation. No done is produced, and p reads 0 after the reset edge.
- Accepting a start:
  - A start is accepted at an edge where start=1 and state is IDLE or DONE.
  - On acceptance: mcand ← {N'b0, a}, mplier ← b, acc ← 0, count ← 0, state ← RUN.
- start=1 while in RUN is ignored. No queuing, and operands are not re-sampled.
- RUN edge, one iteration per edge:
  - acc ← acc + (mplier[0] ? mcand : 0). The add is 2N bits wide, modulo 2^(2N). Overflow cannot occur for unsigned N×N.
  - mcand ← mcand << 1.
  - mplier ← mplier >> 1.
  - count ← count + 1.
- On the RUN edge where count = N−1, the final iteration executes and then:
  - p ← final acc value, i.e. acc + the conditional addend.
  - state ← DONE.
- Latency: start accepted at edge k gives p valid and done=1 in the cycle following edge k+N. At default N=8 that is 9 clock edges from start acceptance to done.
- Iteration count is always exactly N. There is no early termination when mplier becomes 0, so latency is data-independent.
- DONE always leaves after one cycle:
  - to RUN if start=1 (back-to-back operation; done stays a single-cycle pulse);
  - otherwise to IDLE.
- p changes only on a RUN completion edge or on reset. It stays stable through IDLE, through DONE and through the following RUN.
- a and b may change freely after the start-acceptance edge without affecting the result.
- busy and done are fully registered, decoded from state flops only; they are never combinational from start.
- count width is ceil(log2(N))+1 bits. It must not wrap before reaching N−1.

Test Plan:
1. rst=1 for 2 cycles, then start=1 with a=13, b=11 → busy=1 for 8 cycles; done pulses exactly once in the 9th cycle after acceptance; p=143 (0x008F); busy=0 after done.
2. a=255, b=255 → p=0xFE01 at done. Then a=0xFF, b=0x80 → p=0x7F80. Then a=0, b=0xAB → p=0x0000 with the same 9-cycle latency.
3. Start a=6, b=7; on the 3rd RUN cycle pulse start=1 with a=100, b=100 and also change a/b → p=42 at the original done time; no second done follows.
4. Start a=200, b=3; assert rst on the 4th RUN cycle → next cycle busy=0, done=0, p=0. Then start a=3, b=5 → p=15 after 9 edges; no stale done from the aborted run.
5. Back-to-back: hold start=1 continuously with a=9, b=9 then a=12, b=12 presented in the DONE cycle → first done shows p=81 for one cycle, busy rises the next cycle, second done shows p=144. done is never high for 2 consecutive cycles.
6. Idle hold: after a completion with p=143, hold start=0 for 20 cycles → p stays 143, busy=0, done=0 throughout.
